// File: rtl/bp_me_burst_to_lite_mem_cmd.sv
// Packs a BedRock burst memory command (header + dword beats) into one block-wide lite message.
// Optional macro BP_ME_BURST_PACKER_OVERLAP_EN: a new header may load in the same cycle the lite message leaves.
module bp_me_burst_to_lite_mem_cmd
  #(parameter int header_width_p    = 128
   ,parameter int data_width_p      = 64
   ,parameter int block_width_p     = 512
   ,parameter int size_offset_p     = 0
   ,parameter int has_data_offset_p = 3
   )
   (input  logic                     clk_i
   ,input  logic                     reset_i

   ,input  logic [header_width_p-1:0] mem_cmd_header_i
   ,input  logic                     mem_cmd_header_v_i
   ,output logic                     mem_cmd_header_ready_o

   ,input  logic [data_width_p-1:0]  mem_cmd_data_i
   ,input  logic                     mem_cmd_data_v_i
   ,output logic                     mem_cmd_data_ready_o

   ,output logic [header_width_p-1:0] mem_cmd_o
   ,output logic [block_width_p-1:0] mem_cmd_data_o
   ,output logic                     mem_cmd_v_o
   ,input  logic                     mem_cmd_ready_and_i
   );

   localparam int max_beats_lp      = block_width_p / data_width_p;
   localparam int lg_max_beats_lp   = $clog2(max_beats_lp);
   localparam int lg_data_bytes_lp  = $clog2(data_width_p / 8);
   localparam int lg_block_bytes_lp = $clog2(block_width_p / 8);
   localparam int cnt_width_lp      = lg_max_beats_lp + 1;

   typedef enum logic [1:0] {e_ready, e_data, e_send} state_e;

   state_e                    state_r, state_n;
   logic [header_width_p-1:0] header_r;
   logic [block_width_p-1:0]  data_r;
   logic [cnt_width_lp-1:0]   cnt_r;
   logic [cnt_width_lp-1:0]   last_beat;
   logic [2:0]                size_r;
   logic                      has_data_r;
   logic                      incoming_has_data;
   logic                      header_fire, data_fire, send_fire;

   assign size_r            = header_r[size_offset_p +: 3];
   assign has_data_r        = header_r[has_data_offset_p];
   assign incoming_has_data = mem_cmd_header_i[has_data_offset_p];

   assign header_fire = mem_cmd_header_v_i & mem_cmd_header_ready_o;
   assign data_fire   = mem_cmd_data_v_i & mem_cmd_data_ready_o;
   assign send_fire   = mem_cmd_v_o & mem_cmd_ready_and_i;

   // Beat count is a power of two: bytes per message over bytes per beat, clamped to [1, block beats].
   always_comb begin
      int lg_beats;
      lg_beats = int'(size_r) - lg_data_bytes_lp;
      if (lg_beats < 0)               lg_beats = 0;
      if (lg_beats > lg_max_beats_lp) lg_beats = lg_max_beats_lp;
      last_beat = cnt_width_lp'((1 << lg_beats) - 1);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i)
         state_r <= e_ready;
      else
         state_r <= state_n;
   end

   always_comb begin
      state_n = state_r;
      unique case (state_r)
         e_ready: if (header_fire) state_n = incoming_has_data ? e_data : e_send;
         e_data:  if (data_fire && (cnt_r == last_beat)) state_n = e_send;
         e_send:
            if (send_fire) begin
`ifdef BP_ME_BURST_PACKER_OVERLAP_EN
               if (header_fire)
                  state_n = incoming_has_data ? e_data : e_send;
               else
                  state_n = e_ready;
`else
               state_n = e_ready;
`endif
            end
         default: state_n = e_ready;
      endcase
   end

   always_comb begin
      mem_cmd_v_o            = (state_r == e_send);
      mem_cmd_data_ready_o   = (state_r == e_data);
`ifdef BP_ME_BURST_PACKER_OVERLAP_EN
      mem_cmd_header_ready_o = (state_r == e_ready)
                               | ((state_r == e_send) & mem_cmd_ready_and_i);
`else
      mem_cmd_header_ready_o = (state_r == e_ready);
`endif
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         header_r <= '0;
         data_r   <= '0;
         cnt_r    <= '0;
      end
      else begin
         if (header_fire) begin
            header_r <= mem_cmd_header_i;
            cnt_r    <= '0;
         end
         if (data_fire) begin
            data_r[cnt_r*data_width_p +: data_width_p] <= mem_cmd_data_i;
            cnt_r <= cnt_r + cnt_width_lp'(1);
         end
      end
   end

   // One replicated view per possible message size; sizes at or above the block use the raw block.
   logic [block_width_p-1:0] rep [lg_block_bytes_lp+1];
   for (genvar k = 0; k <= lg_block_bytes_lp; k++) begin : g_rep
      localparam int slice_lp = 8 << k;
      assign rep[k] = {(block_width_p/slice_lp){data_r[slice_lp-1:0]}};
   end

   always_comb begin
      mem_cmd_data_o = '0;
      if (has_data_r) begin
         mem_cmd_data_o = rep[lg_block_bytes_lp];
         for (int k = 0; k < lg_block_bytes_lp; k++)
            if (int'(size_r) == k) mem_cmd_data_o = rep[k];
      end
   end

   assign mem_cmd_o = header_r;

endmodule

// File: tb/tb_bp_me_burst_to_lite_mem_cmd.sv
// Self-checking bench for bp_me_burst_to_lite_mem_cmd: vector table, hand sequences, randomized scoreboard.
module tb_bp_me_burst_to_lite_mem_cmd;

   localparam int hw         = 128;
   localparam int dw         = 64;
   localparam int bw         = 512;
   localparam int timeout_lp = 500;
   localparam int n_rand_lp  = 30;

   logic          clk_i = 1'b0;
   logic          reset_i;
   logic [hw-1:0] mem_cmd_header_i;
   logic          mem_cmd_header_v_i;
   logic          mem_cmd_header_ready_o;
   logic [dw-1:0] mem_cmd_data_i;
   logic          mem_cmd_data_v_i;
   logic          mem_cmd_data_ready_o;
   logic [hw-1:0] mem_cmd_o;
   logic [bw-1:0] mem_cmd_data_o;
   logic          mem_cmd_v_o;
   logic          mem_cmd_ready_and_i;

   bp_me_burst_to_lite_mem_cmd dut
     (.clk_i                  (clk_i)
     ,.reset_i                (reset_i)
     ,.mem_cmd_header_i       (mem_cmd_header_i)
     ,.mem_cmd_header_v_i     (mem_cmd_header_v_i)
     ,.mem_cmd_header_ready_o (mem_cmd_header_ready_o)
     ,.mem_cmd_data_i         (mem_cmd_data_i)
     ,.mem_cmd_data_v_i       (mem_cmd_data_v_i)
     ,.mem_cmd_data_ready_o   (mem_cmd_data_ready_o)
     ,.mem_cmd_o              (mem_cmd_o)
     ,.mem_cmd_data_o         (mem_cmd_data_o)
     ,.mem_cmd_v_o            (mem_cmd_v_o)
     ,.mem_cmd_ready_and_i    (mem_cmd_ready_and_i)
     );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [hw-1:0] hdr;
      logic [bw-1:0] payload;
      int            edge_no;
   } xfer_t;

   typedef struct {
      logic [2:0]    size;
      bit            has_data;
      logic [dw-1:0] base;
      logic [dw-1:0] dw0;
      logic [dw-1:0] dw3;
      logic [dw-1:0] dw7;
   } vec_t;

   xfer_t got_q[$];
   int    checks   = 0;
   int    failures = 0;
   int    cycle    = 0;

   always @(posedge clk_i) cycle <= cycle + 1;

   task automatic checkOutput(input string name, input logic [bw-1:0] act, input logic [bw-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic reportTimeout(input string name);
      checks++;
      failures++;
      $display("[TB] FAIL %s actual=timeout required=handshake", name);
   endtask

   // Records every transfer and checks that a stalled message holds still.
   bit            stall_q = 1'b0;
   logic [hw-1:0] stall_hdr;
   logic [bw-1:0] stall_pay;
   always @(negedge clk_i) begin
      if (reset_i) stall_q = 1'b0;
      else begin
         if (stall_q) begin
            checkOutput("stall_v_hdr", bw'({mem_cmd_v_o, mem_cmd_o}), bw'({1'b1, stall_hdr}));
            checkOutput("stall_payload", mem_cmd_data_o, stall_pay);
         end
         if (mem_cmd_v_o && mem_cmd_ready_and_i)
            got_q.push_back('{mem_cmd_o, mem_cmd_data_o, cycle + 1});
         stall_q   = mem_cmd_v_o && !mem_cmd_ready_and_i;
         stall_hdr = mem_cmd_o;
         stall_pay = mem_cmd_data_o;
      end
   end

   function automatic int numBeats(input int size);
      int b;
      b = (8 << size) / dw;
      if (b < 1) b = 1;
      if (b > bw/dw) b = bw/dw;
      return b;
   endfunction

   // Reference: gather the message bytes, then repeat them across the block.
   function automatic logic [bw-1:0] modelPayload(input int size, input bit has_data, input logic [dw-1:0] beats [8]);
      logic [bw-1:0] blk;
      logic [bw-1:0] res;
      int bits;
      blk = '0;
      res = '0;
      if (!has_data) return res;
      bits = 8 << size;
      if (bits > bw) bits = bw;
      for (int i = 0; i < numBeats(size); i++) blk[i*dw +: dw] = beats[i];
      for (int b = 0; b < bw; b++) res[b] = blk[b % bits];
      return res;
   endfunction

   function automatic logic [hw-1:0] makeHeader(input logic [2:0] size, input bit has_data);
      logic [hw-1:0] h;
      h = {$urandom(), $urandom(), $urandom(), $urandom()};
      h[2:0] = size;
      h[3]   = has_data;
      return h;
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic pushHeader(input logic [hw-1:0] h);
      int n = 0;
      mem_cmd_header_i   = h;
      mem_cmd_header_v_i = 1'b1;
      @(negedge clk_i);
      while (!mem_cmd_header_ready_o && n < timeout_lp) begin
         @(negedge clk_i);
         n++;
      end
      if (n >= timeout_lp) reportTimeout("header_handshake");
      tick();
      mem_cmd_header_v_i = 1'b0;
   endtask

   task automatic pushBeat(input logic [dw-1:0] d);
      int n = 0;
      mem_cmd_data_i   = d;
      mem_cmd_data_v_i = 1'b1;
      @(negedge clk_i);
      while (!mem_cmd_data_ready_o && n < timeout_lp) begin
         @(negedge clk_i);
         n++;
      end
      if (n >= timeout_lp) reportTimeout("data_handshake");
      tick();
      mem_cmd_data_v_i = 1'b0;
   endtask

   // Drives one whole burst message with up to gap_max idle cycles before each beat.
   task automatic applyStimulus(input logic [hw-1:0] h, input logic [dw-1:0] beats [8], input int nb, input int gap_max);
      pushHeader(h);
      for (int i = 0; i < nb; i++) begin
         repeat ($urandom_range(0, gap_max)) tick();
         pushBeat(beats[i]);
      end
   endtask

   task automatic waitTransfer(output xfer_t x, output bit ok);
      int n = 0;
      while (got_q.size() == 0 && n < timeout_lp) begin
         tick();
         n++;
      end
      ok = (got_q.size() != 0);
      if (ok) x = got_q.pop_front();
      else begin
         x = '{'0, '0, 0};
         reportTimeout("lite_transfer");
      end
   endtask

   vec_t          vecs [9];
   xfer_t         x;
   xfer_t         exp_q[$];
   bit            ok;
   bit            rand_done;
   logic [hw-1:0] hdr;
   logic [dw-1:0] beats [8];
   int            edges [4];
   int            spacing;

   initial begin
      #400000;
      $display("[TB] FAIL watchdog actual=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vecs[0] = '{3'd6, 1'b1, 64'h0,                64'h0,                64'h3,                64'h7};
      vecs[1] = '{3'd3, 1'b1, 64'hDEADBEEFCAFEF00D, 64'hDEADBEEFCAFEF00D, 64'hDEADBEEFCAFEF00D, 64'hDEADBEEFCAFEF00D};
      vecs[2] = '{3'd6, 1'b0, 64'h55,               64'h0,                64'h0,                64'h0};
      vecs[3] = '{3'd4, 1'b1, 64'h1111000000000000, 64'h1111000000000000, 64'h1111000000000001, 64'h1111000000000001};
      vecs[4] = '{3'd2, 1'b1, 64'h0123456789ABCDEF, 64'h89ABCDEF89ABCDEF, 64'h89ABCDEF89ABCDEF, 64'h89ABCDEF89ABCDEF};
      vecs[5] = '{3'd7, 1'b1, 64'h100,              64'h100,              64'h103,              64'h107};
      vecs[6] = '{3'd0, 1'b1, 64'h0F0F0F0F0F0F0FEF, 64'hEFEFEFEFEFEFEFEF, 64'hEFEFEFEFEFEFEFEF, 64'hEFEFEFEFEFEFEFEF};
      vecs[7] = '{3'd5, 1'b1, 64'h50,               64'h50,               64'h53,               64'h53};
      vecs[8] = '{3'd1, 1'b1, 64'hAAAABBBBCCCC1234, 64'h1234123412341234, 64'h1234123412341234, 64'h1234123412341234};

      reset_i             = 1'b1;
      mem_cmd_header_i    = '0;
      mem_cmd_header_v_i  = 1'b0;
      mem_cmd_data_i      = '0;
      mem_cmd_data_v_i    = 1'b0;
      mem_cmd_ready_and_i = 1'b1;
      repeat (3) @(posedge clk_i);
      #1;
      reset_i = 1'b0;

      checkOutput("reset_v", bw'(mem_cmd_v_o), bw'(1'b0));
      checkOutput("reset_header_ready", bw'(mem_cmd_header_ready_o), bw'(1'b1));
      checkOutput("reset_data_ready", bw'(mem_cmd_data_ready_o), bw'(1'b0));
      checkOutput("reset_header", bw'(mem_cmd_o), '0);

      // Vector table: fixed sizes and beat patterns with hand-derived dwords.
      for (int t = 0; t < 9; t++) begin
         for (int i = 0; i < 8; i++) beats[i] = vecs[t].base + 64'(i);
         hdr = makeHeader(vecs[t].size, vecs[t].has_data);
         applyStimulus(hdr, beats, vecs[t].has_data ? numBeats(int'(vecs[t].size)) : 0, 0);
         checkOutput($sformatf("vec%0d_latency_v", t), bw'(mem_cmd_v_o), bw'(1'b1));
         waitTransfer(x, ok);
         if (ok) begin
            checkOutput($sformatf("vec%0d_header", t), bw'(x.hdr), bw'(hdr));
            checkOutput($sformatf("vec%0d_dw0", t), bw'(x.payload[0*dw +: dw]), bw'(vecs[t].dw0));
            checkOutput($sformatf("vec%0d_dw3", t), bw'(x.payload[3*dw +: dw]), bw'(vecs[t].dw3));
            checkOutput($sformatf("vec%0d_dw7", t), bw'(x.payload[7*dw +: dw]), bw'(vecs[t].dw7));
         end
      end

      // Read: no data beats, valid one cycle after the header, zero payload.
      hdr = makeHeader(3'd6, 1'b0);
      pushHeader(hdr);
      checkOutput("read_v", bw'(mem_cmd_v_o), bw'(1'b1));
      checkOutput("read_data_ready", bw'(mem_cmd_data_ready_o), bw'(1'b0));
      checkOutput("read_header", bw'(mem_cmd_o), bw'(hdr));
      checkOutput("read_payload", mem_cmd_data_o, '0);
      waitTransfer(x, ok);
      checkOutput("read_data_ready_after", bw'(mem_cmd_data_ready_o), bw'(1'b0));

      // Write with random gaps: valid exactly one cycle after the final beat.
      for (int i = 0; i < 8; i++) beats[i] = 64'(i);
      hdr = makeHeader(3'd6, 1'b1);
      pushHeader(hdr);
      for (int i = 0; i < 8; i++) begin
         repeat ($urandom_range(0, 3)) tick();
         pushBeat(beats[i]);
         if (i == 6) checkOutput("gap_v_early", bw'(mem_cmd_v_o), bw'(1'b0));
      end
      checkOutput("gap_v_latency", bw'(mem_cmd_v_o), bw'(1'b1));
      waitTransfer(x, ok);
      if (ok) checkOutput("gap_payload", x.payload, modelPayload(6, 1'b1, beats));

      // Backpressure: consumer stalls for 10 cycles.
      mem_cmd_ready_and_i = 1'b0;
      for (int i = 0; i < 8; i++) beats[i] = {$urandom(), $urandom()};
      hdr = makeHeader(3'd6, 1'b1);
      applyStimulus(hdr, beats, 8, 1);
      for (int c = 0; c < 10; c++) begin
         checkOutput("bp_v", bw'(mem_cmd_v_o), bw'(1'b1));
         checkOutput("bp_header", bw'(mem_cmd_o), bw'(hdr));
         checkOutput("bp_payload", mem_cmd_data_o, modelPayload(6, 1'b1, beats));
         checkOutput("bp_header_ready", bw'(mem_cmd_header_ready_o), bw'(1'b0));
         tick();
      end
      mem_cmd_ready_and_i = 1'b1;
      waitTransfer(x, ok);
      if (ok) checkOutput("bp_xfer_payload", x.payload, modelPayload(6, 1'b1, beats));

      // Reset partway through a write abandons it.
      hdr = makeHeader(3'd6, 1'b1);
      pushHeader(hdr);
      for (int i = 0; i < 3; i++) pushBeat(64'hBAD0 + 64'(i));
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
      checkOutput("midrst_v", bw'(mem_cmd_v_o), bw'(1'b0));
      checkOutput("midrst_header_ready", bw'(mem_cmd_header_ready_o), bw'(1'b1));
      checkOutput("midrst_data_ready", bw'(mem_cmd_data_ready_o), bw'(1'b0));
      hdr = makeHeader(3'd6, 1'b0);
      pushHeader(hdr);
      waitTransfer(x, ok);
      if (ok) begin
         checkOutput("midrst_h2_header", bw'(x.hdr), bw'(hdr));
         checkOutput("midrst_h2_payload", x.payload, '0);
      end
      repeat (3) tick();
      checkOutput("midrst_no_stale", bw'(got_q.size()), bw'(0));
      beats[0] = 64'hA0A0A0A0A0A0A0A0;
      beats[1] = 64'h0B0B0B0B0B0B0B0B;
      hdr = makeHeader(3'd4, 1'b1);
      applyStimulus(hdr, beats, 2, 0);
      waitTransfer(x, ok);
      if (ok) checkOutput("midrst_restart_payload", x.payload, modelPayload(4, 1'b1, beats));

      // Four back-to-back reads with the consumer always ready.
`ifdef BP_ME_BURST_PACKER_OVERLAP_EN
      spacing = 1;
`else
      spacing = 2;
`endif
      for (int k = 0; k < 4; k++) pushHeader(makeHeader(3'd6, 1'b0));
      for (int k = 0; k < 4; k++) begin
         waitTransfer(x, ok);
         edges[k] = x.edge_no;
      end
      for (int k = 1; k < 4; k++)
         checkOutput($sformatf("b2b_spacing%0d", k), bw'(edges[k] - edges[k-1]), bw'(spacing));

      // Randomized messages against the reference model, with random consumer stalls.
      got_q.delete();
      rand_done = 1'b0;
      fork
         begin
            for (int m = 0; m < n_rand_lp; m++) begin
               logic [2:0] sz;
               bit         hd;
               sz = 3'($urandom_range(0, 7));
               hd = 1'($urandom_range(0, 1));
               for (int i = 0; i < 8; i++) beats[i] = {$urandom(), $urandom()};
               hdr = makeHeader(sz, hd);
               exp_q.push_back('{hdr, modelPayload(int'(sz), hd, beats), 0});
               applyStimulus(hdr, beats, hd ? numBeats(int'(sz)) : 0, 2);
            end
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               tick();
               mem_cmd_ready_and_i = ($urandom_range(0, 3) != 0);
            end
         end
      join
      mem_cmd_ready_and_i = 1'b1;
      for (int n = 0; n < timeout_lp && got_q.size() < n_rand_lp; n++) tick();
      checkOutput("rand_count", bw'(got_q.size()), bw'(n_rand_lp));
      while (got_q.size() != 0 && exp_q.size() != 0) begin
         x = got_q.pop_front();
         checkOutput("rand_header", bw'(x.hdr), bw'(exp_q[0].hdr));
         checkOutput("rand_payload", x.payload, exp_q[0].payload);
         void'(exp_q.pop_front());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bp_me_burst_to_lite_mem_cmd.md
Name: bp_me_burst_to_lite_mem_cmd

Overview:
- Downstream neighbour of the CCE's memory-command BedRock burst port.
- Accepts a header beat plus zero or more dword data beats over ready&valid.
- Packs them into one "lite" message: header plus full cce_block_width_p payload.
- Feeds block-wide memory models and DRAM adapters that cannot consume bursts.

Parameters:
- header_width_p, 128, width of the BedRock mem message header (cce_mem_msg_header_width_lp).
- data_width_p, 64, burst data beat width (dword_width_p); power of 2, at least 8.
- block_width_p, 512, lite payload width (cce_block_width_p); a power-of-2 multiple of data_width_p.
- size_offset_p, 0, bit offset in the header of the 3-bit size field; bytes = 1 << size.
- has_data_offset_p, 3, bit offset in the header of the flag marking that data beats follow (write or uncached store).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- mem_cmd_header_i  in  header_width_p  burst header.
- mem_cmd_header_v_i  in  1  header valid.
- mem_cmd_header_ready_o  out  1  header ready.
- mem_cmd_data_i  in  data_width_p  burst data beat.
- mem_cmd_data_v_i  in  1  data valid.
- mem_cmd_data_ready_o  out  1  data ready.
- mem_cmd_o  out  header_width_p  lite header, registered copy of the burst header.
- mem_cmd_data_o  out  block_width_p  lite payload.
- mem_cmd_v_o  out  1  lite message valid.
- mem_cmd_ready_and_i  in  1  consumer ready; transfer when v and ready are both high.

Behaviour:
- Interface: one clock (clk_i); reset_i is synchronous and active-high.
- Reset:
  - state=e_ready, beat counter=0.
  - mem_cmd_v_o=0, mem_cmd_header_ready_o=1 in the first cycle after reset, mem_cmd_data_ready_o=0.
  - header and data registers=0.
- Beat count:
  - beats = max(1, (8 << size) / data_width_p).
  - Saturates at block_width_p / data_width_p; a size larger than the block is clamped.
  - Counter width is log2(block_width_p / data_width_p) + 1.
- e_ready:
  - header_ready=1, data_ready=0.
  - On a header handshake: register the header and clear the counter.
  - Go to e_data if the has_data flag is set, else go to e_send.
- e_data:
  - data_ready=1, header_ready=0.
  - Each data handshake writes the beat into slot [counter*data_width_p +: data_width_p] of the data register and increments the counter.
  - On the handshake where counter == beats-1, go to e_send.
  - Data beats arriving in e_ready are not accepted; they stall.
- e_send:
  - mem_cmd_v_o=1; header and payload are held stable until the transfer.
  - Payload for sub-block sizes: the low (8 << size) bits are replicated across block_width_p.
  - Payload for no-data messages: all zero.
  - On transfer, return to e_ready. Latency from the final input beat to mem_cmd_v_o is exactly 1 cycle.
- Backpressure: mem_cmd_v_o never drops without a transfer, and outputs never change while v=1 and ready=0.
- Reset mid-message: abandons the partial message; no lite output is produced for it.
- Header and data valid together in e_ready: only the header is consumed that cycle; the data is consumed from the next cycle on.

Optional Feature:
- Macro: BP_ME_BURST_PACKER_OVERLAP_EN.
- When defined:
  - In e_send, mem_cmd_header_ready_o = mem_cmd_ready_and_i.
  - A header handshake in the same cycle as the output transfer loads the next header and goes directly to e_data or e_send.
  - This gives back-to-back no-data messages at one per cycle.
- When undefined:
  - header_ready is asserted only in e_ready.
  - Minimum spacing is 2 cycles per message.

Test Plan:
- Read, size=6 (64B), has_data=0, header=H1 → mem_cmd_v_o 1 cycle after the header handshake; mem_cmd_o=H1; payload all zero; data_ready never asserts.
- Write, size=6, 8 beats 0x0..0x7 with random data_v gaps → payload dword i = i; v asserts exactly 1 cycle after beat 7.
- Write, size=3 (8B), one beat 0xDEADBEEFCAFEF00D → payload = that dword replicated 8 times.
- Write, size=6, mem_cmd_ready_and_i held low for 10 cycles → v, header and payload stable throughout; header_ready=0 throughout.
- Reset asserted after 3 of 8 beats, then a read header H2 → only H2 emerges, with no stale write; counter restarts at 0.
- OVERLAP_EN defined, 4 consecutive reads, ready_and always high → outputs on 4 consecutive cycles; undefined → one every 2 cycles.
